serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
- Parallel-to-serial stage directly upstream of the 1101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock on `dout`.
- `dout` drives the detector's `din`, and `dout_valid` qualifies it.
- Supports back-to-back words with no bubble, so bit patterns that span word boundaries stay contiguous for overlapping detection.

Parameters:
- WIDTH, 8, word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b0, value driven on `dout` when no word is being sent.

Ports:
- clk  input  1  single system clock; all state updates on posedge only.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word; captured on handshake.
- in_ready  output  1  feeder can accept a word this cycle (combinational).
- bit_en  input  1  bit-rate strobe; the current bit is consumed at a posedge where bit_en=1.
- dout  output  1  serial bit; registered.
- dout_valid  output  1  dout carries a data bit; registered.
- busy  output  1  word in flight (state == SHIFT).
- word_done  output  1  one-cycle pulse after the final bit of a word is consumed.

Behaviour:
- Reset values (reset_n=0, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - dout = IDLE_BIT, dout_valid = 0, word_done = 0.
  - in_ready follows the IDLE rule, so it is 1 while in reset.
- Handshake: a word is accepted at a posedge where in_valid & in_ready. in_data is sampled on that edge only.
- in_ready = (state==IDLE) | (state==SHIFT & bit_en & cnt==WIDTH-1). It does not depend on in_valid.
- States:
  - IDLE:
    - On accept: load shift register, cnt=0, go to SHIFT.
    - In the next cycle dout = first bit (MSB or LSB per MSB_FIRST) and dout_valid = 1.
    - bit_en is ignored in IDLE.
  - SHIFT, bit_en=0: hold dout, cnt and the shift register (stall).
  - SHIFT, bit_en=1 and cnt < WIDTH-1: shift; dout = next bit; cnt += 1.
  - SHIFT, bit_en=1 and cnt == WIDTH-1 (last bit consumed), word_done pulses next cycle, then:
    - With a simultaneous accept: load the new word, cnt=0, stay in SHIFT. The first bit of the new word appears next cycle with no gap and dout_valid stays 1.
    - Without an accept: go to IDLE; dout = IDLE_BIT, dout_valid = 0.
- Latency: accept edge to first bit on dout = 1 cycle. A word with bit_en held high occupies exactly WIDTH cycles.
- Width rules: cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1. No wrap beyond WIDTH-1; it reloads to 0.
- in_valid while busy and not in the last-bit window is not accepted. Upstream must hold in_data until the handshake.
- Reset mid-word: the partial word is discarded and no word_done is generated. After release the feeder is in IDLE with in_ready = 1.
- reset_n deasserting on the same edge as in_valid: the word is accepted only if reset_n is high at that posedge.
- dout and dout_valid come straight from flops (no combinational path from inputs).

Decomposition:
- Shared package `seq_det_pkg`:
  - state enum {IDLE, SHIFT}.
  - localparam CNT_W = $clog2(WIDTH).
  - IDLE_BIT default constant.
- Optional sub-module `bit_counter`: modulo-WIDTH counter with enable, load and terminal-count outputs. It is instantiated once. Everything else stays inline.

Test Plan:
- WIDTH=8, MSB_FIRST=1, bit_en=1, send 0xD0 → dout = 1,1,0,1,0,0,0,0 on cycles 1..8 after accept. dout_valid high for those 8 cycles, word_done pulse on cycle 9, then dout = 0 and dout_valid = 0.
- Back-to-back 0x0D then 0xB0, in_valid held → in_ready high only in the last-bit cycle. 16 contiguous valid bits 0000_1101_1011_0000 with no bubble; a downstream detector sees 2 overlapping 1101 matches.
- bit_en pattern 1,0,0,1,… during 0xA5 → dout and cnt hold on bit_en=0 cycles. The bit order is still 1,0,1,0,0,1,0,1 and word_done occurs after the 8th enabled edge.
- MSB_FIRST=0, send 0x0B → dout = 1,1,0,1,0,0,0,0.
- Assert reset_n=0 asynchronously mid-cycle during bit 3 of 0xFF → dout = IDLE_BIT and dout_valid = 0 immediately, no word_done. After release, in_ready = 1 and a new word 0x55 serialises correctly.
- in_valid pulsed at bit 4 of an in-flight word → not accepted (in_ready=0). The in-flight word is unaffected and the feeder returns to IDLE afterwards.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the 1101 sequence-detector front end.
//   state_t          : feeder FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH    : default serialised word width
//   CNT_W            : bit-counter width for the default word width
//   IDLE_BIT_DEFAULT : default level driven on the serial line when idle
//   cnt_width()      : counter width for an arbitrary word width
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam int   CNT_W            = $clog2(DEFAULT_WIDTH);
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Counter width able to hold 0..width-1; never less than one bit.
    function automatic int cnt_width(input int width);
        if (width < 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Modulo-MODULUS up-counter used to track the bit position inside a word.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   en      : advance the count by one (wraps to 0 after MODULUS-1)
//   load    : restart the count at 0; takes priority over en
//   cnt     : current count, always in 0..MODULUS-1
//   tc      : terminal count, high while cnt == MODULUS-1
// -----------------------------------------------------------------------------
module bit_counter
    import seq_det_pkg::*;
#(
    parameter int MODULUS  = DEFAULT_WIDTH,
    parameter int CNT_BITS = cnt_width(MODULUS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                load,
    output logic [CNT_BITS-1:0] cnt,
    output logic                tc
);

    localparam logic [CNT_BITS-1:0] ZERO_C = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] ONE_C  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] LAST_C = CNT_BITS'(MODULUS - 1);

    logic [CNT_BITS-1:0] cnt_r;
    logic                tc_s;

    // Terminal-count decode.
    always_comb begin
        tc_s = (cnt_r == LAST_C);
    end

    // Count register: load restarts, enable advances, terminal count wraps to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= ZERO_C;
        end else if (load) begin
            cnt_r <= ZERO_C;
        end else if (en) begin
            if (tc_s) begin
                cnt_r <= ZERO_C;
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = tc_s;

endmodule

// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
// Parallel-to-serial stage feeding the 1101 sequence detector. Words arrive
// over valid/ready and leave one bit per enabled clock; a new word can be
// taken in the last-bit cycle so consecutive words form one unbroken stream.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : upstream word valid
//   in_data    : upstream word, sampled on the accepting edge
//   in_ready   : word can be accepted this cycle (combinational)
//   bit_en     : bit-rate strobe; the current bit is consumed when high
//   dout       : serial bit (registered)
//   dout_valid : dout carries a data bit (registered)
//   busy       : a word is in flight
//   word_done  : one-cycle pulse after the final bit of a word is consumed
// -----------------------------------------------------------------------------
module serial_word_feeder
    import seq_det_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int                  CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    WORD_ZERO = {WIDTH{1'b0}};

    state_t              state_r;
    logic [WIDTH-1:0]    shreg_r;
    logic                dout_r;
    logic                dout_valid_r;
    logic                word_done_r;

    logic [CNT_BITS-1:0] cnt_s;
    logic                tc_s;
    logic                shifting_s;
    logic                last_bit_s;
    logic                in_ready_s;
    logic                accept_s;
    logic [WIDTH-1:0]    shreg_next_s;

    // Bit that goes on the line first for a freshly loaded word.
    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word[WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    // Drop the bit just sent so the next one sits at the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, word[WIDTH-1:1]};
        end
    endfunction

    // Handshake and shift decode. in_ready deliberately ignores in_valid.
    always_comb begin
        shifting_s   = (state_r == SHIFT) && bit_en;
        last_bit_s   = shifting_s && tc_s;
        in_ready_s   = (state_r == IDLE) || (shifting_s && (cnt_s == LAST_CNT));
        accept_s     = in_valid && in_ready_s;
        shreg_next_s = advance(shreg_r);
    end

    // Bit position within the current word; an accept restarts it at 0.
    bit_counter #(
        .MODULUS  (WIDTH),
        .CNT_BITS (CNT_BITS)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (shifting_s),
        .load    (accept_s),
        .cnt     (cnt_s),
        .tc      (tc_s)
    );

    // Feeder FSM with registered serial outputs. The shift register always
    // holds the current bit at its output end, so dout is loaded with the
    // bit that will be on the line after this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            shreg_r      <= WORD_ZERO;
            dout_r       <= IDLE_BIT;
            dout_valid_r <= 1'b0;
            word_done_r  <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r      <= SHIFT;
                        shreg_r      <= in_data;
                        dout_r       <= first_bit(in_data);
                        dout_valid_r <= 1'b1;
                    end else begin
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_bit_s) begin
                        word_done_r <= 1'b1;
                        if (accept_s) begin
                            // Next word follows with no gap on the line.
                            shreg_r      <= in_data;
                            dout_r       <= first_bit(in_data);
                            dout_valid_r <= 1'b1;
                        end else begin
                            state_r      <= IDLE;
                            shreg_r      <= WORD_ZERO;
                            dout_r       <= IDLE_BIT;
                            dout_valid_r <= 1'b0;
                        end
                    end else if (shifting_s) begin
                        shreg_r <= shreg_next_s;
                        dout_r  <= first_bit(shreg_next_s);
                    end else begin
                        // Stall: bit_en low holds the current bit on the line.
                        shreg_r <= shreg_r;
                        dout_r  <= dout_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    shreg_r      <= WORD_ZERO;
                    dout_r       <= IDLE_BIT;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = (state_r == SHIFT);
    assign word_done  = word_done_r;

endmodule

// File: tb/tb_serial_word_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_word_feeder
// Drives two feeders (MSB-first/idle 0 and LSB-first/idle 1) from the same
// inputs and compares every cycle against a queue-of-pending-bits model.
// -----------------------------------------------------------------------------
module tb_serial_word_feeder;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         bit_en;

    logic ready_m, dout_m, dv_m, busy_m, wd_m;
    logic ready_l, dout_l, dv_l, busy_l, wd_l;

    int checks;
    int errors;

    // Model: bits still to appear on each instance's line, current bit first.
    bit mq[2][$];
    bit mdone[2];
    bit recording;
    bit rec[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_m), .bit_en(bit_en), .dout(dout_m), .dout_valid(dv_m),
        .busy(busy_m), .word_done(wd_m)
    );

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_l), .bit_en(bit_en), .dout(dout_l), .dout_valid(dv_l),
        .busy(busy_l), .word_done(wd_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic obs(input int i, input int which);
        case (which)
            0: return (i == 0) ? ready_m : ready_l;
            1: return (i == 0) ? dout_m  : dout_l;
            2: return (i == 0) ? dv_m    : dv_l;
            3: return (i == 0) ? busy_m  : busy_l;
            default: return (i == 0) ? wd_m : wd_l;
        endcase
    endfunction

    function automatic bit idle_lvl(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    // Compare registered outputs of both instances with the model.
    task automatic check_outputs(input string ph);
        for (int i = 0; i < 2; i++) begin
            bit have;
            have = (mq[i].size() > 0);
            check($sformatf("%s.dout_valid[%0d]", ph, i), 32'(obs(i, 2)), 32'(have));
            check($sformatf("%s.dout[%0d]", ph, i), 32'(obs(i, 1)),
                  32'(have ? mq[i][0] : idle_lvl(i)));
            check($sformatf("%s.busy[%0d]", ph, i), 32'(obs(i, 3)), 32'(have));
            check($sformatf("%s.word_done[%0d]", ph, i), 32'(obs(i, 4)), 32'(mdone[i]));
        end
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input string ph, input logic v, input logic [W-1:0] d,
                        input logic en, output logic acc);
        bit exp_ready;
        bit junk;
        in_valid = v;
        in_data  = d;
        bit_en   = en;
        @(negedge clk);
        exp_ready = (mq[0].size() == 0) || (en && mq[0].size() == 1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.in_ready[%0d]", ph, i), 32'(obs(i, 0)), 32'(exp_ready));
        end
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mdone[i] = (mq[i].size() == 1) && en;
            if (mq[i].size() > 0 && en) begin
                junk = mq[i].pop_front();
            end
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    mq[i].push_back((i == 0) ? d[W-1-k] : d[k]);
                end
            end
        end
        check_outputs(ph);
        if (recording && dv_m) begin
            rec.push_back(dout_m);
        end
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the clock edge.
    task automatic reset_mid(input string ph);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mdone[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.rst_ready[%0d]", ph, i), 32'(obs(i, 0)), 32'(1));
        end
        check_outputs({ph, ".rst"});
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs({ph, ".post"});
    endtask

    // Drain: run with a given enable pattern until the model is idle.
    task automatic drain(input string ph, input int mode, input int budget);
        logic acc;
        int   n;
        n = 0;
        while (mq[0].size() > 0 && n < budget) begin
            step(ph, 1'b0, '0, (mode == 0) ? 1'b1 : ((n % 3) == 2), acc);
            n++;
        end
        check({ph, ".drained"}, 32'(dv_m), 32'(0));
    endtask

    function automatic int count_1101();
        int c;
        c = 0;
        for (int k = 3; k < rec.size(); k++) begin
            if (rec[k-3] == 1'b1 && rec[k-2] == 1'b1 && rec[k-1] == 1'b0 && rec[k] == 1'b1) begin
                c++;
            end
        end
        return c;
    endfunction

    initial begin
        logic         acc;
        logic [W-1:0] words[$];
        logic [W-1:0] pend;
        bit           have_pend;
        int           n;

        checks    = 0;
        errors    = 0;
        recording = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bit_en    = 1'b0;
        mdone[0]  = 1'b0;
        mdone[1]  = 1'b0;

        // Reset state.
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset.in_ready[%0d]", i), 32'(obs(i, 0)), 32'(1));
        end
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 0xD0 with bit_en held high, then idle.
        step("d0", 1'b1, 8'hD0, 1'b1, acc);
        drain("d0", 0, 12);
        step("d0_tail", 1'b0, '0, 1'b1, acc);

        // Back-to-back 0x0D, 0xB0 with in_valid held.
        words = '{8'h0D, 8'hB0};
        rec.delete();
        recording = 1'b1;
        n = 0;
        while ((words.size() > 0 || mq[0].size() > 0) && n < 40) begin
            step("b2b", words.size() > 0, (words.size() > 0) ? words[0] : 8'h00, 1'b1, acc);
            if (acc) begin
                void'(words.pop_front());
            end
            n++;
        end
        recording = 1'b0;
        check("b2b.bits", 32'(rec.size()), 32'(16));
        check("b2b.matches_1101", 32'(count_1101()), 32'(2));

        // 0xA5 with a stalling bit_en pattern.
        step("a5", 1'b1, 8'hA5, 1'b0, acc);
        drain("a5", 1, 60);

        // 0x0B: LSB-first instance emits 1,1,0,1,0,0,0,0.
        step("0b", 1'b1, 8'h0B, 1'b1, acc);
        drain("0b", 0, 12);

        // Reset during bit 3 of 0xFF, then 0x55.
        step("ff", 1'b1, 8'hFF, 1'b1, acc);
        step("ff", 1'b0, '0, 1'b1, acc);
        step("ff", 1'b0, '0, 1'b1, acc);
        reset_mid("ff");
        step("55", 1'b1, 8'h55, 1'b1, acc);
        drain("55", 0, 12);

        // in_valid pulse mid-word must be ignored.
        step("mid", 1'b1, 8'h3C, 1'b1, acc);
        for (int k = 0; k < 3; k++) begin
            step("mid", 1'b0, '0, 1'b1, acc);
        end
        step("mid_pulse", 1'b1, 8'h99, 1'b1, acc);
        drain("mid", 0, 12);
        step("mid_tail", 1'b0, '0, 1'b1, acc);

        // Randomised traffic with occasional asynchronous reset.
        have_pend = 1'b0;
        pend      = '0;
        for (int c = 0; c < 600; c++) begin
            if (!have_pend && $urandom_range(0, 2) != 0) begin
                pend      = W'($urandom);
                have_pend = 1'b1;
            end
            step("rand", have_pend && ($urandom_range(0, 3) != 0), pend,
                 $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                have_pend = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) begin
                reset_mid("rand");
            end
        end
        drain("rand", 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
